// File: rtl/stop_watch_lap_pkg.sv
// rtl/stop_watch_lap_pkg.sv - shared types, widths and 7-seg lookup for the lap stopwatch
// Purpose: FSM state encoding, BCD digit width and the digit-to-segment decoder
//          shared by the stopwatch top and its digit counters.
// Ports:   none (package).
package stop_watch_lap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STOP   = 2'd2,
        ST_RECALL = 2'd3
    } sw_state_e;

    localparam int BCD_W      = 4;
    localparam int NUM_DIGITS = 4;
    localparam int TIME_W     = BCD_W * NUM_DIGITS;
    localparam int SEG_W      = 7;

    // Segment order is {g,f,e,d,c,b,a}; the table is active-high and is
    // inverted on the way out for common-anode displays.
    function automatic logic [SEG_W-1:0] bcd_to_7seg(input logic [BCD_W-1:0] digit,
                                                     input logic              active_low);
        logic [SEG_W-1:0] seg;
        case (digit)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
        return active_low ? ~seg : seg;
    endfunction

endpackage

// File: rtl/sw_bcd_digit.sv
// rtl/sw_bcd_digit.sv - one mod-10 BCD counter digit with enable, clear and carry out
// Purpose: a single decade of the SS.hh time; chained via o_carry -> i_en of the next digit.
// Ports:   clk     - system clock
//          i_clr   - synchronous clear to 0 (dominates i_en)
//          i_en    - count enable for this cycle
//          o_q     - current digit value 0..9
//          o_carry - combinational: enabled while at 9, i.e. this digit wraps this cycle
module sw_bcd_digit
    import stop_watch_lap_pkg::*;
(
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [BCD_W-1:0] o_q,
    output logic             o_carry
);

    logic [BCD_W-1:0] r_q;
    logic             w_at_nine;

    assign w_at_nine = (r_q == BCD_W'(9));

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= w_at_nine ? '0 : r_q + BCD_W'(1);
        end
    end

    // Combinational carry so the whole chain ripples in one cycle.
    assign o_carry = i_en && w_at_nine;
    assign o_q     = r_q;

endmodule

// File: rtl/stop_watch_lap.sv
// rtl/stop_watch_lap.sv - SS.hh stopwatch with lap ring buffer, lap recall and overflow flag
// Purpose: turns four debounced active-low pushbuttons into a running/stopped SS.hh
//          time with LAP_DEPTH stored laps, and drives four 7-seg digits.
// Ports:   clk, rst                      - clock, synchronous active-high reset
//          sw_start_stop/clear/lap/recall - debounced buttons, pressed = 0
//          sec_tens/sec_ones/hund_tens/hund_ones_7seg - registered {g..a} digit drives
//          lap_count, lap_full           - stored laps, buffer full
//          running, overflow             - in RUN, sticky 99.99 -> 00.00 wrap seen
module stop_watch_lap
    import stop_watch_lap_pkg::*;
#(
    parameter int CLK_DIV        = 500000,
    parameter int LAP_DEPTH      = 4,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sw_start_stop,
    input  logic                           sw_clear,
    input  logic                           sw_lap,
    input  logic                           sw_recall,
    output logic [SEG_W-1:0]               sec_tens_7seg,
    output logic [SEG_W-1:0]               sec_ones_7seg,
    output logic [SEG_W-1:0]               hund_tens_7seg,
    output logic [SEG_W-1:0]               hund_ones_7seg,
    output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count,
    output logic                           lap_full,
    output logic                           running,
    output logic                           overflow
);

    localparam int   CNT_W   = $clog2(LAP_DEPTH + 1);
    localparam int   PTR_W   = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
    localparam int   PRE_W   = $clog2(CLK_DIV);
    localparam logic ACT_LOW = (SEG_ACTIVE_LOW != 0);

    // Button bit order used throughout: [0] start_stop, [1] clear, [2] lap, [3] recall.
    localparam int B_SS  = 0;
    localparam int B_CLR = 1;
    localparam int B_LAP = 2;
    localparam int B_REC = 3;

    logic [3:0] w_pins;
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic [3:0] r_prev;
    logic [3:0] w_press;

    sw_state_e r_state;
    sw_state_e w_state_nxt;
    logic      w_go_clear;
    logic      w_lap_push;
    logic      w_recall_enter;
    logic      w_recall_adv;

    logic [PRE_W-1:0]  r_presc;
    logic              w_tick;
    logic              w_digit_clr;
    logic [NUM_DIGITS:0] w_en;
    logic [BCD_W-1:0]  w_digit [NUM_DIGITS];
    logic [TIME_W-1:0] w_time;
    logic              r_overflow;

    logic [TIME_W-1:0] r_lap [LAP_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_rd_idx;
    logic [CNT_W-1:0]  r_count;
    logic              w_full;
    logic [PTR_W-1:0]  w_oldest;
    logic [TIME_W-1:0] w_disp;

    logic [SEG_W-1:0]  r_seg3;
    logic [SEG_W-1:0]  r_seg2;
    logic [SEG_W-1:0]  r_seg1;
    logic [SEG_W-1:0]  r_seg0;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(LAP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Synchroniser plus edge detect. Reset to the released level so that
    // pins sitting high after reset never look like a press.
    assign w_pins = {sw_recall, sw_lap, sw_clear, sw_start_stop};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_prev  <= '1;
        end else begin
            r_sync1 <= w_pins;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_press = r_prev & ~r_sync2;

    assign w_full = (r_count == CNT_W'(LAP_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Events that are ignored in the current state do not block lower-priority
    // ones; among events that do apply, clear > start_stop > lap > recall.
    always_comb begin
        w_state_nxt    = r_state;
        w_go_clear     = 1'b0;
        w_lap_push     = 1'b0;
        w_recall_enter = 1'b0;
        w_recall_adv   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_press[B_CLR]) begin
                    w_go_clear = 1'b1;
                end else if (w_press[B_SS]) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_press[B_SS]) begin
                    w_state_nxt = ST_STOP;
                end else if (w_press[B_LAP]) begin
                    w_lap_push = 1'b1;
                end
            end
            ST_STOP: begin
                if (w_press[B_CLR]) begin
                    w_go_clear  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_press[B_SS]) begin
                    w_state_nxt = ST_RUN;
                end else if (w_press[B_REC] && (r_count != '0)) begin
                    w_recall_enter = 1'b1;
                    w_state_nxt    = ST_RECALL;
                end
            end
            ST_RECALL: begin
                if (w_press[B_CLR]) begin
                    w_go_clear  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_press[B_REC]) begin
                    if (r_rd_idx == r_count - CNT_W'(1)) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_recall_adv = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Prescaler only advances in RUN and keeps its phase across a pause,
    // so stop/resume does not lose or gain fractions of a hundredth.
    assign w_tick = (r_state == ST_RUN) && (r_presc == PRE_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || w_go_clear) begin
            r_presc <= '0;
        end else if (r_state == ST_RUN) begin
            r_presc <= w_tick ? '0 : r_presc + PRE_W'(1);
        end
    end

    // Digit 0 is hundredths-ones; each carry enables the next decade.
    assign w_digit_clr = rst || w_go_clear;
    assign w_en[0]     = w_tick;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        sw_bcd_digit u_digit (
            .clk     (clk),
            .i_clr   (w_digit_clr),
            .i_en    (w_en[gi]),
            .o_q     (w_digit[gi]),
            .o_carry (w_en[gi+1])
        );
    end

    assign w_time = {w_digit[3], w_digit[2], w_digit[1], w_digit[0]};

    always_ff @(posedge clk) begin
        if (rst || w_go_clear) begin
            r_overflow <= 1'b0;
        end else if (w_en[NUM_DIGITS]) begin
            r_overflow <= 1'b1;
        end
    end

    // Ring buffer: once full, wr_ptr also points at the oldest entry.
    assign w_oldest = w_full ? r_wr_ptr : '0;

    always_ff @(posedge clk) begin
        if (rst || w_go_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_rd_idx <= '0;
            r_count  <= '0;
        end else begin
            if (w_lap_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
                if (!w_full) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end
            if (w_recall_enter) begin
                r_rd_ptr <= w_oldest;
                r_rd_idx <= '0;
            end else if (w_recall_adv) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
                r_rd_idx <= r_rd_idx + CNT_W'(1);
            end
        end
    end

    // Stores the time before any coincident tick lands.
    always_ff @(posedge clk) begin
        if (w_lap_push) begin
            r_lap[r_wr_ptr] <= w_time;
        end
    end

    assign w_disp = (r_state == ST_RECALL) ? r_lap[r_rd_ptr] : w_time;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg3 <= bcd_to_7seg('0, ACT_LOW);
            r_seg2 <= bcd_to_7seg('0, ACT_LOW);
            r_seg1 <= bcd_to_7seg('0, ACT_LOW);
            r_seg0 <= bcd_to_7seg('0, ACT_LOW);
        end else begin
            r_seg3 <= bcd_to_7seg(w_disp[15:12], ACT_LOW);
            r_seg2 <= bcd_to_7seg(w_disp[11:8], ACT_LOW);
            r_seg1 <= bcd_to_7seg(w_disp[7:4], ACT_LOW);
            r_seg0 <= bcd_to_7seg(w_disp[3:0], ACT_LOW);
        end
    end

    assign sec_tens_7seg  = r_seg3;
    assign sec_ones_7seg  = r_seg2;
    assign hund_tens_7seg = r_seg1;
    assign hund_ones_7seg = r_seg0;
    assign lap_count      = r_count;
    assign lap_full       = w_full;
    assign running        = (r_state == ST_RUN);
    assign overflow       = r_overflow;

endmodule
